// File: rtl/cache_bus_arbiter.sv
// Two-to-one SRAM-like bus arbiter that lets the instruction and data caches share the bridge port.
// Define ARB_STARVE_GUARD_EN to add a guard that keeps the instruction cache from being starved.
module cache_bus_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [31:0] inst_addr,
   input  logic [31:0] inst_wdata,
   output logic [31:0] inst_rdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,

   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic [31:0] data_rdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,

   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_size,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t state, state_next;
   logic   grant_d, grant_d_next;
   logic   pick_data;
   logic   gnt_req;

   // pick_data is the arbitration decision used when a grant is issued from IDLE
`ifdef ARB_STARVE_GUARD_EN
   logic [3:0] starve_cnt;
   logic       starve_hit;

   assign starve_hit = (starve_cnt == 4'(STARVE_LIMIT));
   assign pick_data  = data_req & ~(inst_req & starve_hit);

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (state == IDLE && (inst_req || data_req)) begin
         if (pick_data && inst_req)
            starve_cnt <= starve_cnt + 4'd1;
         else
            starve_cnt <= '0;
      end
   end
`else
   assign pick_data = data_req;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         grant_d <= 1'b0;
      end else begin
         state   <= state_next;
         grant_d <= grant_d_next;
      end
   end

   assign gnt_req = grant_d ? data_req : inst_req;

   // An ADDR cycle whose requester has dropped req abandons the grant without touching the bridge
   always_comb begin
      state_next   = state;
      grant_d_next = grant_d;
      mem_req      = 1'b0;
      case (state)
         IDLE: begin
            if (inst_req || data_req) begin
               grant_d_next = pick_data;
               state_next   = ADDR;
            end
         end
         ADDR: begin
            mem_req = gnt_req;
            if (!gnt_req)
               state_next = IDLE;
            else if (mem_addr_ok)
               state_next = mem_data_ok ? IDLE : DATA;
         end
         DATA: begin
            if (mem_data_ok)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign mem_wr    = grant_d ? data_wr    : inst_wr;
   assign mem_size  = grant_d ? data_size  : inst_size;
   assign mem_addr  = grant_d ? data_addr  : inst_addr;
   assign mem_wdata = grant_d ? data_wdata : inst_wdata;

   assign inst_rdata = mem_rdata;
   assign data_rdata = mem_rdata;

   assign inst_addr_ok = mem_addr_ok & (state == ADDR) & ~grant_d;
   assign data_addr_ok = mem_addr_ok & (state == ADDR) &  grant_d;
   assign inst_data_ok = mem_data_ok & (state == ADDR || state == DATA) & ~grant_d;
   assign data_data_ok = mem_data_ok & (state == ADDR || state == DATA) &  grant_d;

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed bench for cache_bus_arbiter; read data is checked through a scoreboard of expected responses.
module tb_cache_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_req, inst_wr, data_req, data_wr;
   logic [1:0]  inst_size, data_size, mem_size;
   logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
   logic [31:0] inst_rdata, data_rdata;
   logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
   logic        mem_req, mem_wr;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_addr_ok, mem_data_ok;

   typedef struct packed {
      logic        port;
      logic [31:0] rdata;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   logic exp_inst[6];

   cache_bus_arbiter #(.STARVE_LIMIT(2)) dut (
      .clk(clk), .rst(rst),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
      .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Moves to the next cycle (just after the rising edge) and drives the request/bridge controls
   task automatic applyStimulus(input logic ireq, input logic dreq, input logic aok,
                                input logic dok, input logic [31:0] rdata);
      @(posedge clk);
      #1;
      inst_req    = ireq;
      data_req    = dreq;
      mem_addr_ok = aok;
      mem_data_ok = dok;
      mem_rdata   = rdata;
   endtask

   task automatic pushExpect(input logic port, input logic [31:0] rdata);
      exp_t e;
      e.port  = port;
      e.rdata = rdata;
      sb.push_back(e);
   endtask

   // Samples on the falling edge; any data_ok must match the oldest scoreboard entry
   task automatic checkOutput(input string tag, input logic mreq, input logic iaok,
                              input logic idok, input logic daok, input logic ddok);
      exp_t e;
      @(negedge clk);
      chk({tag, ":mem_req"}, mem_req, mreq);
      chk({tag, ":inst_addr_ok"}, inst_addr_ok, iaok);
      chk({tag, ":inst_data_ok"}, inst_data_ok, idok);
      chk({tag, ":data_addr_ok"}, data_addr_ok, daok);
      chk({tag, ":data_data_ok"}, data_data_ok, ddok);
      if (inst_data_ok || data_data_ok) begin
         if (sb.size() == 0) begin
            chk({tag, ":sb_pending"}, sb.size(), 1);
         end else begin
            e = sb.pop_front();
            chk({tag, ":sb_port"}, data_data_ok, e.port);
            chk({tag, ":sb_rdata"}, data_data_ok ? data_rdata : inst_rdata, e.rdata);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = 32'h1111_0000; inst_wdata = 32'h1111_AAAA;
      data_req = 0; data_wr = 1; data_size = 2'd1; data_addr = 32'h2222_0000; data_wdata = 32'h2222_BBBB;
      mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;

      // Reset state: acks suppressed even with bridge strobes high, mux follows instruction port
      applyStimulus(0, 0, 1, 1, 32'h0);
      applyStimulus(0, 0, 1, 1, 32'h0);
      checkOutput("rst", 0, 0, 0, 0, 0);
      chk("rst:mem_addr", mem_addr, 32'h1111_0000);
      chk("rst:mem_wdata", mem_wdata, 32'h1111_AAAA);
      chk("rst:mem_size", mem_size, 2'd2);

      // Instruction read with an immediate bridge
      applyStimulus(1, 0, 0, 0, 32'h0);
      rst = 1'b0; inst_addr = 32'hBFC0_0000; inst_wr = 0;
      checkOutput("t1c0", 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 1, 1, 32'h3C1D_0000);
      pushExpect(1'b0, 32'h3C1D_0000);
      checkOutput("t1c1", 1, 1, 1, 0, 0);
      chk("t1c1:mem_addr", mem_addr, 32'hBFC0_0000);
      applyStimulus(0, 0, 1, 1, 32'h0);
      checkOutput("t1c2_idle", 0, 0, 0, 0, 0);

      // Simultaneous requests: data write first, instruction after the bubble
      applyStimulus(1, 1, 0, 0, 32'h0);
      inst_addr = 32'hBFC0_0010;
      data_addr = 32'h8000_1000; data_wdata = 32'h1234_5678; data_wr = 1;
      checkOutput("t2c0", 0, 0, 0, 0, 0);
      applyStimulus(1, 1, 1, 0, 32'h0);
      checkOutput("t2c1", 1, 0, 0, 1, 0);
      chk("t2c1:mem_wr", mem_wr, 1'b1);
      chk("t2c1:mem_addr", mem_addr, 32'h8000_1000);
      chk("t2c1:mem_wdata", mem_wdata, 32'h1234_5678);
      applyStimulus(1, 0, 0, 0, 32'h0);
      checkOutput("t2c2", 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 1, 32'hA5A5_A5A5);
      pushExpect(1'b1, 32'hA5A5_A5A5);
      checkOutput("t2c3", 0, 0, 0, 0, 1);
      applyStimulus(1, 0, 1, 0, 32'h0);
      checkOutput("t2c4_bubble", 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 1, 1, 32'h0000_1234);
      pushExpect(1'b0, 32'h0000_1234);
      checkOutput("t2c5", 1, 1, 1, 0, 0);
      chk("t2c5:mem_addr", mem_addr, 32'hBFC0_0010);
      chk("t2c5:mem_wr", mem_wr, 1'b0);
      applyStimulus(0, 0, 0, 0, 32'h0);
      checkOutput("t2c6", 0, 0, 0, 0, 0);

      // Split phases on a data read
      applyStimulus(0, 1, 0, 0, 32'h0);
      data_addr = 32'h8000_2000; data_wr = 0;
      checkOutput("t3c0", 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 1, 0, 32'h0);
      checkOutput("t3c1", 1, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 32'h0);
      checkOutput("t3c2", 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 32'h0);
      checkOutput("t3c3", 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 1, 32'hCAFE_F00D);
      pushExpect(1'b1, 32'hCAFE_F00D);
      checkOutput("t3c4", 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 32'h0);
      checkOutput("t3c5", 0, 0, 0, 0, 0);

      // Reset while a data transaction sits in its data phase
      applyStimulus(0, 1, 0, 0, 32'h0);
      data_addr = 32'h8000_3000; inst_addr = 32'hBFC0_0020;
      checkOutput("t4c0", 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 1, 0, 32'h0);
      checkOutput("t4c1", 1, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 32'h0);
      rst = 1'b1;
      checkOutput("t4c2", 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 1, 32'h5555_5555);
      rst = 1'b0;
      checkOutput("t4c3", 0, 0, 0, 0, 0);
      chk("t4c3:mem_addr", mem_addr, 32'hBFC0_0020);
      applyStimulus(0, 0, 0, 0, 32'h0);
      checkOutput("t4c4", 0, 0, 0, 0, 0);

      // Abandoned data request, then an instruction request is granted
      applyStimulus(0, 1, 0, 0, 32'h0);
      data_addr = 32'h8000_4000;
      checkOutput("t5c0", 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 32'h0);
      checkOutput("t5c1", 1, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 32'h0);
      inst_addr = 32'hBFC0_0030;
      checkOutput("t5c2", 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 32'h0);
      checkOutput("t5c3", 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 1, 1, 32'h1111_2222);
      pushExpect(1'b0, 32'h1111_2222);
      checkOutput("t5c4", 1, 1, 1, 0, 0);
      chk("t5c4:mem_addr", mem_addr, 32'hBFC0_0030);
      applyStimulus(0, 0, 0, 0, 32'h0);
      checkOutput("t5c5", 0, 0, 0, 0, 0);

      // Both caches requesting continuously
`ifdef ARB_STARVE_GUARD_EN
      exp_inst = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
`else
      exp_inst = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
      for (int k = 0; k < 6; k++) begin
         applyStimulus(1, 1, 0, 0, 32'h0);
         inst_addr = 32'hBFC0_0040; data_addr = 32'h8000_5000;
         checkOutput($sformatf("t6_idle%0d", k), 0, 0, 0, 0, 0);
         applyStimulus(1, 1, 1, 1, 32'h7700_0000 + 32'(k));
         pushExpect(~exp_inst[k], 32'h7700_0000 + 32'(k));
         checkOutput($sformatf("t6_grant%0d", k), 1, exp_inst[k], exp_inst[k], ~exp_inst[k], ~exp_inst[k]);
         chk($sformatf("t6_addr%0d", k), mem_addr, exp_inst[k] ? 32'hBFC0_0040 : 32'h8000_5000);
      end
      applyStimulus(0, 0, 0, 0, 32'h0);
      checkOutput("t6_end", 0, 0, 0, 0, 0);

      chk("sb_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
